result_bcd_conv: RTL and testbench
==================================

Name: result_bcd_conv

Overview:
- Downstream stage of the math unit: takes its signed 32-bit result and converts the magnitude to packed BCD digits plus a sign flag for the seven-segment display driver.
- Iterative shift-add-3 (double-dabble) converter, one bit per clock.
- Valid/ready handshake on both sides, so the display path can stall it.

Parameters:
- W, 32, input result width in bits (matches math unit result width).
- DIGITS, 10, BCD digits produced; must satisfy 10^DIGITS > 2^(W-1) (10 digits cover 2147483648).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  result and in_valid_res are presented.
- in_ready  output  1  converter can accept a new result.
- in_result  input  W  signed two's-complement result.
- in_valid_res  input  1  math unit valid flag, captured with the operand.
- out_valid  output  1  conversion complete, outputs stable.
- out_ready  input  1  display consumer accepts the output.
- out_bcd  output  4*DIGITS  packed BCD; digit 0 (units) in [3:0].
- out_neg  output  1  original result was negative.
- out_err  output  1  captured in_valid_res was 0.
- out_blank  output  DIGITS  leading-zero blank mask; bit i = 1 blanks digit i.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state IDLE.
  - out_valid=0, out_bcd=0, out_neg=0, out_err=0, out_blank=0.
  - in_ready=1 once rst_n deasserts.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- in_ready = (state==IDLE), combinational from state only. out_valid = (state==DONE), registered.
- IDLE, accept edge (in_valid && in_ready):
  - Capture magnitude: in_result negative -> mag = two's-complement negation, computed W bits wide and treated as unsigned (-2^(W-1) yields 2^(W-1)); otherwise mag = in_result.
  - Capture out_neg = in_result[W-1], and err = ~in_valid_res.
  - Clear the BCD accumulator; bit counter = W-1; go to SHIFT.
- SHIFT, each edge:
  - Every BCD nibble >= 5 gets +3.
  - Then shift {bcd, mag} left by one.
  - When counter reaches 0 after this shift, go to DONE; otherwise decrement.
  - Exactly W edges spent in SHIFT.
- Latency: out_valid rises on the W-th edge after the accept edge (32 clocks at default).
- DONE:
  - out_bcd, out_neg, out_err, out_blank held stable while out_valid=1 and out_ready=0 (arbitrary stall length).
  - out_valid && out_ready on an edge -> IDLE. out_valid drops next cycle; in_ready rises the same cycle.
  - No overlap: throughput is one conversion per W+2 clocks minimum.
- in_valid while not in_ready is ignored; in_result may change freely then.
- Zero result: out_bcd=0, out_neg=0. No negative zero is possible.
- out_err=1: digit/sign outputs still carry the converted in_result; the display decides what to show.
- Reset asserted in SHIFT or DONE: conversion aborted, all outputs to reset values immediately (async). No partial result is ever presented.
- out_bcd in IDLE/SHIFT: holds last converted value; only meaningful while out_valid=1.

Optional Feature:
- Macro RESULT_BCD_BLANK_EN.
- Defined: out_blank is registered on entry to DONE. Bit i = 1 iff digit i and all higher digits are zero, for i >= 1. Bit 0 is never blanked (zero shows "0").
- Not defined: out_blank tied to all zeros; no blank logic synthesised.
- Port list is identical either way.

Decomposition:
- Shared calc package:
  - RESULT_W=32, BCD_DIGITS=10 constants.
  - bcd_digit_t (logic [3:0]).
  - conv_state_t enum {IDLE, SHIFT, DONE}.
- One sub-module: bcd_add3_nibble. Combinational nibble >= 5 ? +3 : pass, instantiated DIGITS times via generate.

Test Plan:
- Result 0, valid_res=1 -> after 32 clocks out_valid=1, out_bcd=0x0000000000, out_neg=0, out_err=0; with macro out_blank=10'b1111111110.
- Result 12345 -> out_bcd=0x0000012345, out_neg=0; with macro out_blank=10'b1111100000; out_valid exactly 32 edges after accept.
- Result -2147483648 -> out_bcd=0x2147483648, out_neg=1; result -1 -> out_bcd=0x0000000001, out_neg=1.
- Result 405 with out_ready held 0 for 7 cycles after out_valid -> outputs stable, in_ready=0, an extra in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
- Result 99, valid_res=0 -> out_bcd=0x0000000099, out_err=1; back-to-back results 7 then 8 each produce correct separate outputs.
- rst_n pulsed low at SHIFT cycle 15 -> out_valid=0 and in_ready=1 after release; next result 42 converts to 0x0000000042.

Source files
------------

// File: rtl/result_bcd_conv_pkg.sv
// result_bcd_conv_pkg: shared constants and types for the result-to-BCD converter
package result_bcd_conv_pkg;

    localparam int RESULT_W   = 32;
    localparam int BCD_DIGITS = 10;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

endpackage

// File: rtl/bcd_add3_nibble.sv
// bcd_add3_nibble: double-dabble digit correction, adds 3 to a nibble of 5 or more
module bcd_add3_nibble
    import result_bcd_conv_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/result_bcd_conv.sv
// result_bcd_conv: signed result to packed BCD magnitude plus sign, one bit per clock
// Optional leading-zero blank mask enabled by defining RESULT_BCD_BLANK_EN.
module result_bcd_conv
    import result_bcd_conv_pkg::*;
#(
    parameter int W      = RESULT_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_result,
    input  logic                in_valid_res,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_neg,
    output logic                out_err,
    output logic [DIGITS-1:0]   out_blank
);

    localparam int CW = $clog2(W);

    conv_state_t         state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [W-1:0]        mag;
    logic [4*DIGITS-1:0] bcd, adj, bcd_nxt;
    logic                neg, err;
    logic                accept, last;

    assign accept  = in_valid && in_ready;
    assign last    = (state == SHIFT) && (cnt == '0);
    assign bcd_nxt = {adj[4*DIGITS-2:0], mag[W-1]};

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3_nibble u_add3 (
            .d(bcd[4*i +: 4]),
            .q(adj[4*i +: 4])
        );
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state: accept -> shift W bits -> hold until consumer takes it
    always_comb begin
        state_nxt = accept                           ? SHIFT :
                    last                             ? DONE  :
                    (state == DONE && out_ready)     ? IDLE  : state;
    end

    // handshake outputs decoded from the state register only
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // capture operand, run shift-add-3, publish result on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mag     <= '0;
            bcd     <= '0;
            neg     <= 1'b0;
            err     <= 1'b0;
            out_bcd <= '0;
            out_neg <= 1'b0;
            out_err <= 1'b0;
        end else if (accept) begin
            mag <= in_result[W-1] ? -in_result : in_result;
            neg <= in_result[W-1];
            err <= ~in_valid_res;
            bcd <= '0;
            cnt <= CW'(W - 1);
        end else if (state == SHIFT) begin
            bcd <= bcd_nxt;
            mag <= {mag[W-2:0], 1'b0};
            cnt <= cnt - CW'(1);
            if (last) begin
                out_bcd <= bcd_nxt;
                out_neg <= neg;
                out_err <= err;
            end
        end
    end

`ifdef RESULT_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;

    // digit i blanks when it and every higher digit are zero; units never blank
    always_comb begin
        logic z;
        z         = 1'b1;
        blank_nxt = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z            = z && (bcd_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = z;
        end
    end

    // blank mask registered alongside the digits on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    out_blank <= '0;
        else if (last) out_blank <= blank_nxt;
    end
`else
    assign out_blank = '0;
`endif

endmodule

// File: tb/tb_result_bcd_conv.sv
// tb_result_bcd_conv: directed scoreboard bench for result_bcd_conv
module tb_result_bcd_conv;

    typedef struct packed {
        logic [39:0] bcd;
        logic        neg;
        logic        err;
        logic [9:0]  blank;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic        in_valid_res = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [39:0] out_bcd;
    logic        out_neg;
    logic        out_err;
    logic [9:0]  out_blank;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    result_bcd_conv dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_result(in_result),
        .in_valid_res(in_valid_res),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bcd(out_bcd),
        .out_neg(out_neg),
        .out_err(out_err),
        .out_blank(out_blank)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] exp_blank(input longint m);
        logic [9:0] b;
        b = '0;
`ifdef RESULT_BCD_BLANK_EN
        begin
            int     nd;
            longint t;
            nd = 1;
            t  = m / 10;
            while (t > 0) begin
                nd++;
                t = t / 10;
            end
            for (int i = 1; i < 10; i++) b[i] = (i >= nd);
        end
`endif
        return b;
    endfunction

    task automatic convert(input logic [31:0] r, input logic vres, input logic [39:0] ebcd, input int stall);
        exp_t   e;
        int     n;
        longint s;
        s = longint'($signed(r));
        e.bcd   = ebcd;
        e.neg   = r[31];
        e.err   = ~vres;
        e.blank = exp_blank(s < 0 ? -s : s);
        check("in_ready_idle", 64'(in_ready), 64'(1));
        in_valid     = 1'b1;
        in_result    = r;
        in_valid_res = vres;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_result = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'(32));
        e = sb.pop_front();
        for (int k = 0; k < stall; k++) begin
            if (k == 2) begin
                in_valid  = 1'b1;
                in_result = 32'h0000_0005;
            end
            @(posedge clk); #1;
            check("stall_valid", 64'(out_valid), 64'(1));
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_bcd", 64'(out_bcd), 64'(e.bcd));
        end
        in_valid = 1'b0;
        check("bcd", 64'(out_bcd), 64'(e.bcd));
        check("neg", 64'(out_neg), 64'(e.neg));
        check("err", 64'(out_err), 64'(e.err));
        check("blank", 64'(out_blank), 64'(e.blank));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'(0));
        check("release_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #20;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_bcd", 64'(out_bcd), 64'(0));
        check("rst_neg", 64'(out_neg), 64'(0));
        check("rst_err", 64'(out_err), 64'(0));
        check("rst_blank", 64'(out_blank), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));

        convert(32'd0, 1'b1, 40'h00_0000_0000, 0);
        convert(32'd12345, 1'b1, 40'h00_0001_2345, 0);
        convert(32'h8000_0000, 1'b1, 40'h21_4748_3648, 0);
        convert(32'hFFFF_FFFF, 1'b1, 40'h00_0000_0001, 0);
        convert(32'd405, 1'b1, 40'h00_0000_0405, 7);
        convert(32'd99, 1'b0, 40'h00_0000_0099, 0);
        convert(32'd7, 1'b1, 40'h00_0000_0007, 0);
        convert(32'd8, 1'b1, 40'h00_0000_0008, 0);

        in_valid     = 1'b1;
        in_result    = 32'd123456;
        in_valid_res = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("abort_valid", 64'(out_valid), 64'(0));
        check("abort_bcd", 64'(out_bcd), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        check("abort_no_ghost", 64'(out_valid), 64'(0));

        convert(32'd42, 1'b1, 40'h00_0000_0042, 0);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
